// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin owner of the single VGA plot port, held until the owner's last pixel.
// Optional hold watchdog built only when DRAW_ARB_WATCHDOG_EN is defined.
module draw_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int MAX_HOLD = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         pix_valid,
    input  logic [NUM_REQ-1:0]         pix_last,
    input  logic [NUM_REQ*X_W-1:0]     x_in,
    input  logic [NUM_REQ*Y_W-1:0]     y_in,
    input  logic [NUM_REQ*COL_W-1:0]   col_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [X_W-1:0]             plot_x,
    output logic [Y_W-1:0]             plot_y,
    output logic [COL_W-1:0]           plot_col,
    output logic                       plot_en,
    output logic                       timeout
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_REL
    } state_e;

    state_e         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  rr_q, rr_d;
    logic [OW-1:0]  pick;
    logic           pick_vld;
    int             scan_idx;

    logic           own_valid;
    logic           own_last;
    logic           own_req;
    logic           own_done;
    logic           accept;
    logic           wd_hit;

    logic [X_W-1:0]   sel_x, plot_x_q;
    logic [Y_W-1:0]   sel_y, plot_y_q;
    logic [COL_W-1:0] sel_col, plot_col_q;
    logic             plot_en_q;

    // First set request at or above rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_q) + i) % NUM_REQ;
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick     = OW'(scan_idx);
            end
        end
    end

    assign own_valid = pix_valid[owner_q];
    assign own_last  = pix_last[owner_q];
    assign own_req   = req[owner_q];
    assign own_done  = own_valid && own_last;

    assign sel_x   = x_in[int'(owner_q)*X_W +: X_W];
    assign sel_y   = y_in[int'(owner_q)*Y_W +: Y_W];
    assign sel_col = col_in[int'(owner_q)*COL_W +: COL_W];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                if (pick_vld) begin
                    state_d = S_GRANT;
                    owner_d = pick;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // A last pixel wins over abort and watchdog and is still plotted.
                if (own_done) begin
                    accept  = 1'b1;
                    state_d = S_REL;
                end else if (!own_req || wd_hit) begin
                    state_d = S_REL;
                end else begin
                    accept = own_valid;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
                rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_x_q   <= '0;
            plot_y_q   <= '0;
            plot_col_q <= '0;
            plot_en_q  <= 1'b0;
        end else begin
            plot_en_q <= accept;
            if (accept) begin
                plot_x_q   <= sel_x;
                plot_y_q   <= sel_y;
                plot_col_q <= sel_col;
            end
        end
    end

`ifdef DRAW_ARB_WATCHDOG_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q;

    // Counts GRANT cycles; zero on the first cycle of each grant.
    assign hold_d = (state_q == S_GRANT) ? hold_q + 1'b1 : '0;
    assign wd_hit = (state_q == S_GRANT) && (hold_q == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= wd_hit && own_req && !own_done;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        grant = '0;
        if (state_q == S_GRANT) grant[owner_q] = 1'b1;
    end

    assign owner    = owner_q;
    assign busy     = (state_q == S_GRANT);
    assign plot_x   = plot_x_q;
    assign plot_y   = plot_y_q;
    assign plot_col = plot_col_q;
    assign plot_en  = plot_en_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of ownership, rotation and plotted pixels.
module tb_draw_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int OW = $clog2(N);
`ifdef DRAW_ARB_WATCHDOG_EN
    localparam int MH = 8;
`else
    localparam int MH = 255;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req, pix_valid, pix_last;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] col_in;
    logic [N-1:0]    grant;
    logic [OW-1:0]   owner;
    logic            busy;
    logic [XW-1:0]   plot_x;
    logic [YW-1:0]   plot_y;
    logic [CW-1:0]   plot_col;
    logic            plot_en;
    logic            timeout;

    logic [XW-1:0] px [N];
    logic [YW-1:0] py [N];
    logic [CW-1:0] pc [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        x_in   = '0;
        y_in   = '0;
        col_in = '0;
        for (int i = 0; i < N; i++) begin
            x_in[i*XW +: XW]   = px[i];
            y_in[i*YW +: YW]   = py[i];
            col_in[i*CW +: CW] = pc[i];
        end
    end

    draw_arbiter #(
        .NUM_REQ (N),
        .X_W     (XW),
        .Y_W     (YW),
        .COL_W   (CW),
        .MAX_HOLD(MH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .pix_valid(pix_valid),
        .pix_last (pix_last),
        .x_in     (x_in),
        .y_in     (y_in),
        .col_in   (col_in),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .plot_x   (plot_x),
        .plot_y   (plot_y),
        .plot_col (plot_col),
        .plot_en  (plot_en),
        .timeout  (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pix(int i, bit v, bit l);
        pix_valid[i] = v;
        pix_last[i]  = l;
        px[i]        = XW'($urandom);
        py[i]        = YW'($urandom);
        pc[i]        = CW'($urandom);
    endtask

    task automatic quiet();
        req       = '0;
        pix_valid = '0;
        pix_last  = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        quiet();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    function automatic int rr_pick(logic [N-1:0] r, int ptr);
        for (int i = 0; i < N; i++)
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        quiet();
        for (int i = 0; i < N; i++) put_pix(i, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (grant !== '0 || owner !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got grant=%b owner=%0d busy=%b want 0 0 0",
                     grant, owner, busy);
        end
        checks++;
        if (plot_en !== 1'b0 || plot_x !== '0 || plot_y !== '0 ||
            plot_col !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_plot: got en=%b x=%0d y=%0d c=%0d to=%b want all 0",
                     plot_en, plot_x, plot_y, plot_col, timeout);
        end
        resetn = 1'b1;
    endtask

    task automatic test_single();
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: got grant=%b busy=%b want 000 0", grant, busy);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || owner !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_lat2: got grant=%b owner=%0d busy=%b want 010 1 1",
                     grant, owner, busy);
        end
        for (int k = 0; k < 4; k++) begin
            put_pix(1, 1'b1, k == 3);
            ex = px[1];
            ey = py[1];
            ec = pc[1];
            tick();
            checks++;
            if (plot_en !== 1'b1 || plot_x !== ex || plot_y !== ey || plot_col !== ec) begin
                errors++;
                $display("FAIL single_pix%0d: got en=%b x=%0d y=%0d c=%0d want 1 %0d %0d %0d",
                         k, plot_en, plot_x, plot_y, plot_col, ex, ey, ec);
            end
        end
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant=%b busy=%b want 000 0", grant, busy);
        end
        quiet();
        tick();
        checks++;
        if (plot_en !== 1'b0 || owner !== 2'd1) begin
            errors++;
            $display("FAIL single_after: got en=%b owner=%0d want 0 1", plot_en, owner);
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        logic [N-1:0] eg;
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            eg = '0;
            eg[order[g]] = 1'b1;
            for (int t = 0; t < 8 && grant == '0; t++) tick();
            checks++;
            if (grant !== eg || owner !== OW'(order[g])) begin
                errors++;
                $display("FAIL rr_grant%0d: got grant=%b owner=%0d want %b %0d",
                         g, grant, owner, eg, order[g]);
            end
            for (int k = 0; k < 2; k++) begin
                put_pix(order[g], 1'b1, k == 1);
                tick();
                checks++;
                if (plot_en !== 1'b1 || plot_x !== px[order[g]] ||
                    $countones(grant) > 1) begin
                    errors++;
                    $display("FAIL rr_pix%0d_%0d: got en=%b x=%0d grant=%b want 1 %0d onehot",
                             g, k, plot_en, plot_x, grant, px[order[g]]);
                end
            end
            pix_valid = '0;
            pix_last  = '0;
        end
        quiet();
    endtask

    task automatic test_abort();
        logic [XW-1:0] sx;
        do_reset();
        req = 3'b100;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL abort_grant: got grant=%b want 100", grant);
        end
        put_pix(2, 1'b1, 1'b0);
        sx = px[2];
        tick();
        checks++;
        if (plot_en !== 1'b1 || plot_x !== sx) begin
            errors++;
            $display("FAIL abort_pix: got en=%b x=%0d want 1 %0d", plot_en, plot_x, sx);
        end
        req = 3'b011;
        put_pix(2, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot_en !== 1'b0 || plot_x !== sx || grant !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop: got en=%b x=%0d grant=%b want 0 %0d 000",
                     plot_en, plot_x, grant, sx);
        end
        pix_valid = '0;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL abort_next: got grant=%b want 001", grant);
        end
        put_pix(0, 1'b1, 1'b1);
        tick();
        checks++;
        if (plot_en !== 1'b1 || plot_x !== px[0] || grant !== 3'b000) begin
            errors++;
            $display("FAIL one_pixel: got en=%b x=%0d grant=%b want 1 %0d 000",
                     plot_en, plot_x, grant, px[0]);
        end
        quiet();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b010;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        put_pix(1, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got en=%b busy=%b want 1 1", plot_en, busy);
        end
        put_pix(1, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || plot_en !== 1'b0 || busy !== 1'b0 || owner !== '0) begin
            errors++;
            $display("FAIL mid_async: got grant=%b en=%b busy=%b owner=%0d want 0 0 0 0",
                     grant, plot_en, busy, owner);
        end
        tick();
        resetn = 1'b1;
        req    = '0;
        for (int t = 0; t < 4; t++) begin
            put_pix(1, 1'b1, 1'b0);
            tick();
            checks++;
            if (plot_en !== 1'b0 || grant !== '0) begin
                errors++;
                $display("FAIL mid_noplot%0d: got en=%b grant=%b want 0 000",
                         t, plot_en, grant);
            end
        end
        pix_valid = '0;
        req = 3'b010;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        put_pix(1, 1'b1, 1'b1);
        tick();
        checks++;
        if (plot_en !== 1'b1 || plot_x !== px[1] || plot_y !== py[1]) begin
            errors++;
            $display("FAIL mid_regrant: got en=%b x=%0d y=%0d want 1 %0d %0d",
                     plot_en, plot_x, plot_y, px[1], py[1]);
        end
        quiet();
    endtask

    task automatic test_hold();
        logic [XW-1:0] sx;
        do_reset();
        req = 3'b001;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        sx = '0;
`ifdef DRAW_ARB_WATCHDOG_EN
        for (int k = 0; k < MH; k++) begin
            put_pix(0, 1'b1, 1'b0);
            tick();
            if (k < MH - 1) begin
                sx = px[0];
                checks++;
                if (plot_en !== 1'b1 || plot_x !== sx || grant !== 3'b001 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_hold%0d: got en=%b x=%0d grant=%b to=%b want 1 %0d 001 0",
                             k, plot_en, plot_x, grant, timeout, sx);
                end
            end else begin
                checks++;
                if (plot_en !== 1'b0 || plot_x !== sx || grant !== 3'b000 || timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL wd_force: got en=%b x=%0d grant=%b to=%b want 0 %0d 000 1",
                             plot_en, plot_x, grant, timeout, sx);
                end
            end
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse: got to=%b want 0", timeout);
        end
`else
        for (int k = 0; k < 120; k++) begin
            put_pix(0, 1'b1, 1'b0);
            sx = px[0];
            tick();
            checks++;
            if (plot_en !== 1'b1 || plot_x !== sx || grant !== 3'b001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got en=%b x=%0d grant=%b to=%b want 1 %0d 001 0",
                         k, plot_en, plot_x, grant, timeout, sx);
            end
        end
`endif
        quiet();
    endtask

    task automatic test_nonowner();
        logic [XW-1:0] ax;
        logic [YW-1:0] ay;
        logic [CW-1:0] ac;
        do_reset();
        req = 3'b010;
        for (int t = 0; t < 8 && grant == '0; t++) tick();
        put_pix(1, 1'b1, 1'b0);
        put_pix(0, 1'b1, 1'b0);
        put_pix(2, 1'b1, 1'b1);
        ax = px[1];
        ay = py[1];
        ac = pc[1];
        tick();
        checks++;
        if (plot_en !== 1'b1 || plot_x !== ax || plot_y !== ay || plot_col !== ac) begin
            errors++;
            $display("FAIL nonown_own: got en=%b x=%0d y=%0d c=%0d want 1 %0d %0d %0d",
                     plot_en, plot_x, plot_y, plot_col, ax, ay, ac);
        end
        pix_valid[1] = 1'b0;
        put_pix(0, 1'b1, 1'b1);
        put_pix(2, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot_en !== 1'b0 || plot_x !== ax || plot_y !== ay || plot_col !== ac ||
            grant !== 3'b010) begin
            errors++;
            $display("FAIL nonown_ignore: got en=%b x=%0d y=%0d c=%0d g=%b want 0 %0d %0d %0d 010",
                     plot_en, plot_x, plot_y, plot_col, grant, ax, ay, ac);
        end
        pix_valid = '0;
        put_pix(1, 1'b1, 1'b1);
        tick();
        checks++;
        if (plot_en !== 1'b1 || plot_x !== px[1] || grant !== 3'b000) begin
            errors++;
            $display("FAIL nonown_last: got en=%b x=%0d grant=%b want 1 %0d 000",
                     plot_en, plot_x, grant, px[1]);
        end
        quiet();
    endtask

    task automatic test_random();
        int m_ptr, m_owner, m_hold, ev, o;
        bit m_active, rel_pending, exp_pen, exp_to, jr, ab, vl, lt, fr;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        logic [N-1:0]  prev_req, exp_g;
        int rem [N];
        int sent [N];
        int ab_at [N];
        do_reset();
        m_ptr = 0; m_owner = 0; m_hold = 0; o = 0;
        m_active = 0; rel_pending = 0; exp_pen = 0; exp_to = 0;
        ex = '0; ey = '0; ec = '0;
        prev_req = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; sent[i] = 0; ab_at[i] = -1;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            checks++;
            if (plot_en !== exp_pen || plot_x !== ex || plot_y !== ey || plot_col !== ec) begin
                errors++;
                $display("FAIL rnd_plot c%0d: got en=%b x=%0d y=%0d c=%0d want %b %0d %0d %0d",
                         cyc, plot_en, plot_x, plot_y, plot_col, exp_pen, ex, ey, ec);
            end
            checks++;
            if (timeout !== exp_to) begin
                errors++;
                $display("FAIL rnd_timeout c%0d: got %b want %b", cyc, timeout, exp_to);
            end
            jr = 1'b0;
            exp_g = '0;
            if (rel_pending) begin
                m_active    = 1'b0;
                rel_pending = 1'b0;
                m_ptr       = (m_owner + 1) % N;
                req[m_owner] = 1'b0;
                jr = 1'b1;
            end else if (m_active) begin
                exp_g[m_owner] = 1'b1;
            end else if (grant !== '0) begin
                ev = rr_pick(prev_req, m_ptr);
                if (ev >= 0) begin
                    exp_g[ev] = 1'b1;
                    m_active  = 1'b1;
                    m_owner   = ev;
                    m_hold    = 0;
                end
            end
            checks++;
            if (grant !== exp_g || (m_active && owner !== OW'(m_owner))) begin
                errors++;
                $display("FAIL rnd_grant c%0d: got grant=%b owner=%0d want %b %0d",
                         cyc, grant, owner, exp_g, m_owner);
            end
            exp_pen = 1'b0;
            exp_to  = 1'b0;
            for (int i = 0; i < N; i++) begin
                put_pix(i, ($urandom % 4) == 0, $urandom % 2);
                if (!req[i] && !(jr && i == m_owner) && ($urandom % 8) == 0) begin
                    req[i]   = 1'b1;
                    rem[i]   = 1 + int'($urandom % 4);
                    sent[i]  = 0;
                    ab_at[i] = (($urandom % 5) == 0) ? int'($urandom % rem[i]) : -1;
                end
            end
            if (m_active) begin
                o = m_owner;
                m_hold++;
                ab = (sent[o] == ab_at[o]) && (($urandom % 2) == 0);
                vl = !ab && (($urandom % 10) < 7);
                lt = vl && (rem[o] == 1);
                fr = 1'b0;
`ifdef DRAW_ARB_WATCHDOG_EN
                fr = !ab && !lt && (m_hold == MH);
`endif
                pix_valid[o] = ab ? 1'($urandom % 2) : vl;
                pix_last[o]  = lt;
                if (ab) req[o] = 1'b0;
                if (vl && !fr) begin
                    exp_pen = 1'b1;
                    ex = px[o];
                    ey = py[o];
                    ec = pc[o];
                    sent[o]++;
                    rem[o]--;
                end
                rel_pending = ab || lt || fr;
                exp_to = fr;
            end
            prev_req = req;
        end
        quiet();
    endtask

    initial begin
        resetn = 1'b0;
        quiet();
        for (int i = 0; i < N; i++) begin
            px[i] = '0;
            py[i] = '0;
            pc[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_reset_mid();
        test_hold();
        test_nonowner();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
